// File: rtl/ddr_uart_pkg.sv
// Shared types and default constants for the UART-FIFO to DDR3 write path.
// Holds the drain-controller state encoding and the width helpers used by its sub-blocks.
package ddr_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  localparam int W_DATA_DEF         = 8;
  localparam int ADDR_W_DEF         = 8;
  localparam int BYTES_PER_WORD_DEF = 16;
  localparam int DDR_ADDR_W_DEF     = 28;
  localparam int ADDR_STEP_DEF      = 8;
  localparam int TIMEOUT_DEF        = 1024;

  // The byte count must reach BYTES_PER_WORD itself, hence the +1.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int BYTE_CNT_W_DEF = cnt_width(BYTES_PER_WORD_DEF);

endpackage

// File: rtl/fifo_byte_packer.sv
// Packs captured FIFO bytes into one DDR word, lane 0 first.
// Tracks the fill level and derives the byte-lane write mask from it.
module fifo_byte_packer
  import ddr_uart_pkg::*;
#(
  parameter int W_DATA         = W_DATA_DEF,
  parameter int BYTES_PER_WORD = BYTES_PER_WORD_DEF,
  parameter int CNT_W          = cnt_width(BYTES_PER_WORD)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             capture,
  input  logic                             clear,
  input  logic [W_DATA-1:0]                din,
  output logic [W_DATA*BYTES_PER_WORD-1:0] data,
  output logic [CNT_W-1:0]                 byte_cnt,
  output logic [BYTES_PER_WORD-1:0]        mask
);

  logic word_full;
  assign word_full = (byte_cnt == CNT_W'(BYTES_PER_WORD));

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      data     <= '0;
      byte_cnt <= '0;
    end else if (capture && !word_full) begin
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        if (byte_cnt == CNT_W'(k)) data[k*W_DATA +: W_DATA] <= din;
      end
      byte_cnt <= byte_cnt + 1'b1;
    end
  end

  // Lanes at or above the fill level were never written and must be masked off.
  // NOTE: defaulting every always_comb output first keeps this from inferring latches.
  always_comb begin
    mask = '0;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      mask[k] = (CNT_W'(k) >= byte_cnt);
    end
  end

endmodule

// File: rtl/ddr_fifo_drain_ctrl.sv
// Drains the UART byte FIFO into DDR3-width write requests with auto-incrementing address.
// Partial words are flushed with byte masks on idle timeout or when draining is disabled.
module ddr_fifo_drain_ctrl
  import ddr_uart_pkg::*;
#(
  parameter int W_DATA         = W_DATA_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int BYTES_PER_WORD = BYTES_PER_WORD_DEF,
  parameter int DDR_ADDR_W     = DDR_ADDR_W_DEF,
  parameter int ADDR_STEP      = ADDR_STEP_DEF,
  parameter int TIMEOUT        = TIMEOUT_DEF
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_enable,
  input  logic [DDR_ADDR_W-1:0]            i_base_addr,
  input  logic                             i_fifo_empty,
  input  logic [ADDR_W-1:0]                i_fifo_cnt,
  output logic                             o_fifo_rd_en,
  input  logic [W_DATA-1:0]                i_fifo_rdata,
  output logic                             o_wr_valid,
  input  logic                             i_wr_ready,
  output logic [DDR_ADDR_W-1:0]            o_wr_addr,
  output logic [W_DATA*BYTES_PER_WORD-1:0] o_wr_data,
  output logic [BYTES_PER_WORD-1:0]        o_wr_mask,
  output logic                             o_busy,
  output logic [31:0]                      o_words_written
);

  localparam int CNT_W = cnt_width(BYTES_PER_WORD);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t                    state, next_state;
  logic                      inflight;
  logic [TMR_W-1:0]          timer;
  logic [CNT_W-1:0]          byte_cnt;
  logic [CNT_W:0]            pending;
  logic [BYTES_PER_WORD-1:0] pk_mask;
  logic has_bytes, word_full, timeout_hit, flush_req, go_issue;
  logic room, pace_ok, handshake, rd_en;

  assign has_bytes   = (byte_cnt != '0);
  assign word_full   = (byte_cnt == CNT_W'(BYTES_PER_WORD));
  assign timeout_hit = (timer == TMR_W'(TIMEOUT - 1));
  assign pending     = {1'b0, byte_cnt} + {{CNT_W{1'b0}}, inflight};
  assign room        = (pending < (CNT_W+1)'(BYTES_PER_WORD));
  // The occupancy may lag a read by a cycle, so a lone byte is never read twice in a row.
  assign pace_ok     = !inflight || (i_fifo_cnt >= ADDR_W'(2));
  // A flush waits for any outstanding byte so it lands in the word being issued.
  assign flush_req   = has_bytes && !inflight && (timeout_hit || !i_enable);
  assign go_issue    = (word_full && !inflight) || flush_req;
  assign handshake   = (state == ISSUE) && i_wr_ready;

  always_comb begin
    next_state = state;
    rd_en      = 1'b0;
    case (state)
      IDLE: begin
        if (i_enable) next_state = FILL;
      end
      FILL: begin
        rd_en = i_enable && !i_fifo_empty && room && pace_ok && !go_issue;
        if (go_issue)                                   next_state = ISSUE;
        else if (!i_enable && !has_bytes && !inflight)  next_state = IDLE;
      end
      ISSUE: begin
        if (i_wr_ready) next_state = i_enable ? FILL : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      inflight <= 1'b0;
    end else begin
      state    <= next_state;
      inflight <= rd_en;
    end
  end

  // Idle timer only runs while a partial word waits and nothing is arriving.
  always_ff @(posedge i_clk) begin
    if (i_rst || state != FILL || inflight || !has_bytes) timer <= '0;
    else if (!timeout_hit)                                timer <= timer + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wr_addr       <= '0;
      o_words_written <= '0;
    end else if (state == IDLE && i_enable) begin
      o_wr_addr <= i_base_addr;
    end else if (handshake) begin
      o_wr_addr       <= o_wr_addr + DDR_ADDR_W'(ADDR_STEP);
      o_words_written <= o_words_written + 32'd1;
    end
  end

  fifo_byte_packer #(
    .W_DATA         (W_DATA),
    .BYTES_PER_WORD (BYTES_PER_WORD),
    .CNT_W          (CNT_W)
  ) u_packer (
    .clk      (i_clk),
    .rst      (i_rst),
    .capture  (inflight),
    .clear    (handshake),
    .din      (i_fifo_rdata),
    .data     (o_wr_data),
    .byte_cnt (byte_cnt),
    .mask     (pk_mask)
  );

  assign o_fifo_rd_en = rd_en;
  assign o_wr_valid   = (state == ISSUE);
  assign o_wr_mask    = o_wr_valid ? pk_mask : '0;
  assign o_busy       = (state != IDLE);

endmodule

// File: tb/tb_ddr_fifo_drain_ctrl.sv
// Directed bench for ddr_fifo_drain_ctrl with a behavioural FIFO and a handshake recorder.
// Expected words are written out by hand from the pushed byte sequences.
module tb_ddr_fifo_drain_ctrl;

  localparam int W_DATA = 8, ADDR_W = 8, BPW = 16, DDR_ADDR_W = 28, ADDR_STEP = 8, TIMEOUT = 1024;

  logic                  clk = 1'b0, rst = 1'b0, enable = 1'b0, wr_ready = 1'b0;
  logic [DDR_ADDR_W-1:0] base_addr = '0;
  logic                  fifo_empty, rd_en, wr_valid, busy;
  logic [ADDR_W-1:0]     fifo_cnt = '0;
  logic [W_DATA-1:0]     fifo_rdata = '0;
  logic [DDR_ADDR_W-1:0] wr_addr;
  logic [127:0]          wr_data;
  logic [15:0]           wr_mask;
  logic [31:0]           words;
  logic                  push_en = 1'b0;
  logic [7:0]            push_data = '0;

  logic [7:0]            fq[$];
  logic [DDR_ADDR_W-1:0] hs_addr[$];
  logic [127:0]          hs_data[$];
  logic [15:0]           hs_mask[$];
  int                    hs_cyc[$];
  int cyc = 0, err_rd_empty = 0, err_rd_issue = 0;
  int n_checks = 0, n_fail = 0;

  assign fifo_empty = (fifo_cnt == '0);

  ddr_fifo_drain_ctrl #(
    .W_DATA(W_DATA), .ADDR_W(ADDR_W), .BYTES_PER_WORD(BPW),
    .DDR_ADDR_W(DDR_ADDR_W), .ADDR_STEP(ADDR_STEP), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_base_addr(base_addr),
    .i_fifo_empty(fifo_empty), .i_fifo_cnt(fifo_cnt), .o_fifo_rd_en(rd_en),
    .i_fifo_rdata(fifo_rdata), .o_wr_valid(wr_valid), .i_wr_ready(wr_ready),
    .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_wr_mask(wr_mask),
    .o_busy(busy), .o_words_written(words)
  );

  always #5 clk = ~clk;

  // Synchronous FIFO model: read data appears the cycle after rd_en, count is exact.
  always @(posedge clk) begin
    if (rd_en && fq.size() > 0) fifo_rdata <= fq.pop_front();
    if (push_en) fq.push_back(push_data);
    fifo_cnt <= ADDR_W'(fq.size());
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (wr_valid && wr_ready) begin
      hs_addr.push_back(wr_addr);
      hs_data.push_back(wr_data);
      hs_mask.push_back(wr_mask);
      hs_cyc.push_back(cyc);
    end
    if (rd_en && fifo_empty) err_rd_empty <= err_rd_empty + 1;
    if (rd_en && wr_valid)   err_rd_issue <= err_rd_issue + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; wr_ready = 1'b0; push_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic push_bytes(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      push_en = 1'b1; push_data = first + 8'(i);
      tick();
    end
    push_en = 1'b0;
  endtask

  task automatic wait_hs(input string tag, input int target, input int budget);
    int n = 0;
    while (hs_addr.size() < target && n < budget) begin tick(); n++; end
    check({tag, "_hs_count"}, 128'(hs_addr.size()), 128'(target));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    check({tag, "_idle"}, 128'(busy), 128'(0));
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!wr_valid && n < budget) begin tick(); n++; end
    check({tag, "_valid"}, 128'(wr_valid), 128'(1));
  endtask

  task automatic check_word(input string tag, input int idx, input logic [DDR_ADDR_W-1:0] ea,
                            input logic [127:0] ed, input logic [15:0] em);
    if (idx < hs_addr.size()) begin
      check({tag, "_addr"}, 128'(hs_addr[idx]), 128'(ea));
      check({tag, "_data"}, hs_data[idx], ed);
      check({tag, "_mask"}, 128'(hs_mask[idx]), 128'(em));
    end else begin
      check({tag, "_present"}, 128'(hs_addr.size()), 128'(idx + 1));
    end
  endtask

  function automatic logic [7:0] tr_byte(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  initial begin
    int n0, last_push, gap, stall_bad;
    logic [DDR_ADDR_W-1:0] sa;
    logic [127:0] sd, exp_d;
    logic [15:0] sm;

    // Reset state
    do_reset();
    check("rst_valid", 128'(wr_valid), 128'(0));
    check("rst_rd_en", 128'(rd_en), 128'(0));
    check("rst_busy",  128'(busy), 128'(0));
    check("rst_addr",  128'(wr_addr), 128'(0));
    check("rst_data",  wr_data, 128'(0));
    check("rst_mask",  128'(wr_mask), 128'(0));
    check("rst_words", 128'(words), 128'(0));

    // One full word from a preloaded FIFO
    n0 = hs_addr.size();
    base_addr = 28'h0000100; wr_ready = 1'b1;
    push_bytes(8'h00, 16);
    enable = 1'b1;
    wait_hs("t1", n0 + 1, 200);
    check_word("t1_w0", n0, 28'h0000100, 128'h0F0E0D0C0B0A09080706050403020100, 16'h0000);
    check("t1_words", 128'(words), 128'(1));
    enable = 1'b0;
    wait_idle("t1", 50);

    // 40 bytes: two full words, then an 8-byte partial after the idle timeout
    do_reset();
    n0 = hs_addr.size();
    base_addr = 28'h0000200; wr_ready = 1'b1; enable = 1'b1;
    push_bytes(8'h20, 40);
    last_push = cyc;
    wait_hs("t2", n0 + 3, 1500);
    check_word("t2_w0", n0,     28'h0000200, 128'h2F2E2D2C2B2A29282726252423222120, 16'h0000);
    check_word("t2_w1", n0 + 1, 28'h0000208, 128'h3F3E3D3C3B3A39383736353433323130, 16'h0000);
    check_word("t2_w2", n0 + 2, 28'h0000210, 128'h00000000000000004746454443424140, 16'hFF00);
    gap = (hs_cyc.size() > n0 + 2) ? hs_cyc[n0 + 2] - last_push : 0;
    check("t2_timeout_window", 128'(gap >= 1020 && gap <= 1060), 128'(1));
    check("t2_words", 128'(words), 128'(3));
    enable = 1'b0;
    wait_idle("t2", 50);

    // Backpressure: request held 50 cycles with bytes waiting in the FIFO
    do_reset();
    n0 = hs_addr.size();
    base_addr = 28'h0000300; wr_ready = 1'b0; enable = 1'b1;
    push_bytes(8'h60, 20);
    wait_valid("t3", 100);
    sa = wr_addr; sd = wr_data; sm = wr_mask;
    check("t3_snap_addr", 128'(sa), 128'(28'h0000300));
    check("t3_snap_data", sd, 128'h6F6E6D6C6B6A69686766656463626160);
    check("t3_snap_mask", 128'(sm), 128'(0));
    stall_bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (wr_valid !== 1'b1 || wr_addr !== sa || wr_data !== sd || wr_mask !== sm || rd_en !== 1'b0)
        stall_bad++;
    end
    check("t3_stall_stable", 128'(stall_bad), 128'(0));
    wr_ready = 1'b1;
    @(negedge clk); #1;
    check("t3_first_ready", 128'(hs_addr.size()), 128'(n0 + 1));
    repeat (12) tick();
    enable = 1'b0;
    wait_hs("t3", n0 + 2, 50);
    check_word("t3_w1", n0 + 1, 28'h0000308, 128'h00000000000000000000000073727170, 16'hFFF0);
    check("t3_words", 128'(words), 128'(2));
    wait_idle("t3", 50);

    // Trickle: occupancy toggling between 1 and 0 over 64 bytes
    do_reset();
    n0 = hs_addr.size();
    base_addr = 28'h0000400; wr_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 64; i++) begin
      push_en = 1'b1; push_data = tr_byte(i);
      tick();
      push_en = 1'b0;
      repeat ((i % 3 == 0) ? 2 : 1) tick();
    end
    wait_hs("t4", n0 + 4, 200);
    for (int w = 0; w < 4; w++) begin
      exp_d = '0;
      for (int k = 0; k < 16; k++) exp_d[k*8 +: 8] = tr_byte(w * 16 + k);
      check_word($sformatf("t4_w%0d", w), n0 + w, 28'h0000400 + 28'(w * 8), exp_d, 16'h0000);
    end
    check("t4_words", 128'(words), 128'(4));
    enable = 1'b0;
    wait_idle("t4", 50);

    // Disable after 5 bytes: masked flush, then address wrap at the top of DDR space
    do_reset();
    n0 = hs_addr.size();
    base_addr = 28'hFFFFFF8; wr_ready = 1'b1; enable = 1'b1;
    push_bytes(8'h50, 5);
    repeat (10) tick();
    enable = 1'b0;
    wait_hs("t5", n0 + 1, 50);
    check_word("t5_w0", n0, 28'hFFFFFF8, 128'h00000000000000000000005453525150, 16'hFFE0);
    wait_idle("t5", 50);
    check("t5_busy", 128'(busy), 128'(0));
    check("t5_addr_wrap", 128'(wr_addr), 128'(0));
    check("t5_words", 128'(words), 128'(1));

    // Reset while a request is pending
    do_reset();
    base_addr = 28'h0000600; wr_ready = 1'b0; enable = 1'b1;
    push_bytes(8'h80, 16);
    wait_valid("t6", 100);
    rst = 1'b1;
    tick();
    check("t6_valid", 128'(wr_valid), 128'(0));
    check("t6_rd_en", 128'(rd_en), 128'(0));
    check("t6_busy",  128'(busy), 128'(0));
    check("t6_addr",  128'(wr_addr), 128'(0));
    check("t6_data",  wr_data, 128'(0));
    check("t6_mask",  128'(wr_mask), 128'(0));
    check("t6_words", 128'(words), 128'(0));
    rst = 1'b0; enable = 1'b0;
    tick();

    check("rd_while_empty", 128'(err_rd_empty), 128'(0));
    check("rd_while_issue", 128'(err_rd_issue), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
